// File: rtl/ap_ctrl_hs_driver.sv
// Initiator for the ap_ctrl_hs block-level handshake: issues N starts into an HLS core, retires ap_done pulses.
// Latency: ap_start is a registered-state decode; counters and status update one cycle after each handshake.
// Backpressure: ap_start holds until ap_ready; issue stalls at MAX_OUT in flight; cmd_ready only in IDLE.
// Optional latency statistics (timestamp FIFO, cycle counter) are built when LATENCY_STATS_EN is defined.
module ap_ctrl_hs_driver #(
  parameter int unsigned NUM_W   = 16,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [NUM_W-1:0] cmd_count_i,
  output logic             ap_start_o,
  input  logic             ap_ready_i,
  input  logic             ap_done_i,
  output logic             ap_continue_o,
  output logic             busy_o,
  output logic             done_pulse_o,
  output logic [NUM_W-1:0] issued_o,
  output logic [NUM_W-1:0] completed_o,
  output logic             proto_err_o,
  output logic [CNT_W-1:0] last_latency_o,
  output logic [CNT_W-1:0] max_latency_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [NUM_W-1:0] count_q, count_d;
  logic [NUM_W-1:0] issued_q, issued_d;
  logic [NUM_W-1:0] completed_q, completed_d;
  logic             proto_err_q, proto_err_d;

  logic             accept;
  logic [NUM_W-1:0] outstanding;
  logic             start_w;
  logic             start_hs;
  logic             retire;
  logic             bad_done;

  assign accept      = cmd_valid_i && (state_q == S_IDLE);
  assign outstanding = issued_q - completed_q;
  // Depends on registered state only, so ap_start cannot drop mid-handshake.
  assign start_w     = (state_q == S_RUN) && (outstanding < NUM_W'(MAX_OUT));
  assign start_hs    = start_w && ap_ready_i;
  // A done in the same cycle as a start is legal even with nothing in flight (combinational core).
  assign retire      = ap_done_i && ((outstanding != '0) || start_hs);
  assign bad_done    = ap_done_i && !retire;

  // Next-state for the command length, issue/complete counters and the sticky protocol error.
  always_comb begin
    count_d     = count_q;
    issued_d    = issued_q;
    completed_d = completed_q;
    proto_err_d = proto_err_q;
    if (accept) begin
      count_d     = cmd_count_i;
      issued_d    = '0;
      completed_d = '0;
      proto_err_d = 1'b0;
    end else begin
      if (start_hs) issued_d    = issued_q + NUM_W'(1);
      if (retire)   completed_d = completed_q + NUM_W'(1);
    end
    if (bad_done) proto_err_d = 1'b1;
  end

  // Counter registers; reset aborts any run in progress.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q     <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Sequencer next state: issue all starts, wait for all dones, pulse once, return to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (cmd_count_i == '0) ? S_DONE : S_RUN;
      S_RUN:   if (start_hs && ((issued_q + NUM_W'(1)) == count_q)) state_d = S_DRAIN;
      S_DRAIN: if (completed_d == count_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign done_pulse_o  = (state_q == S_DONE);
  assign ap_start_o    = start_w;
  assign ap_continue_o = 1'b1;
  assign issued_o      = issued_q;
  assign completed_o   = completed_q;
  assign proto_err_o   = proto_err_q;

`ifdef LATENCY_STATS_EN
  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  // FIFO occupancy always equals outstanding, so no separate fill count is kept.
  logic [CNT_W-1:0] ts_mem_q [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] lat;
  logic             bypass;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Start and done in one cycle with nothing queued: zero latency, the timestamp is never stored.
  assign bypass = retire && (outstanding == '0);
  assign push   = start_hs && !bypass;
  assign pop    = retire && !bypass;
  assign lat    = bypass ? '0 : (cycle_q - ts_mem_q[rd_ptr_q]);

  // Next state for cycle counter, FIFO pointers and latency statistics.
  always_comb begin
    cycle_d  = cycle_q + CNT_W'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    max_d    = max_q;
    if (accept) begin
      cycle_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      max_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (retire) begin
        last_d = lat;
        if (lat >= max_q) max_d = lat;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cycle_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      max_q    <= '0;
    end else begin
      cycle_q  <= cycle_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
      max_q    <= max_d;
    end
  end

  // Timestamp storage; contents are only read behind a valid read pointer, so no reset is needed.
  always_ff @(posedge clock_i) begin
    if (push) ts_mem_q[wr_ptr_q] <= cycle_q;
  end

  assign last_latency_o = last_q;
  assign max_latency_o  = max_q;
`else
  assign last_latency_o = '0;
  assign max_latency_o  = '0;
`endif

endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// Self-checking bench for ap_ctrl_hs_driver: transaction-level reference model plus directed/random runs.
// Model tracks counts, timestamps as absolute cycle numbers and the completion cycle of each command.
// A simple core model answers starts with ap_done after a configurable delay, in order.
module tb_ap_ctrl_hs_driver;
  localparam int NUM_W   = 16;
  localparam int CNT_W   = 32;
  localparam int MAX_OUT = 4;
`ifdef LATENCY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [NUM_W-1:0] cmd_count;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             busy;
  logic             done_pulse;
  logic [NUM_W-1:0] issued;
  logic [NUM_W-1:0] completed;
  logic             proto_err;
  logic [CNT_W-1:0] last_latency;
  logic [CNT_W-1:0] max_latency;

  logic tie_mode  = 1'b0;
  logic rdy_drv   = 1'b0;
  logic done_drv  = 1'b0;
  logic spur_done = 1'b0;
  int   rdy_pct   = 100;
  int   dmin      = 1;
  int   dmax      = 1;

  assign ap_ready = tie_mode ? ap_start : rdy_drv;
  assign ap_done  = tie_mode ? ap_start : (done_drv | spur_done);

  always #5 clk = ~clk;

  ap_ctrl_hs_driver #(.NUM_W(NUM_W), .CNT_W(CNT_W), .MAX_OUT(MAX_OUT)) dut (
    .clock_i        (clk),
    .reset_i        (reset),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_count_i    (cmd_count),
    .ap_start_o     (ap_start),
    .ap_ready_i     (ap_ready),
    .ap_done_i      (ap_done),
    .ap_continue_o  (ap_continue),
    .busy_o         (busy),
    .done_pulse_o   (done_pulse),
    .issued_o       (issued),
    .completed_o    (completed),
    .proto_err_o    (proto_err),
    .last_latency_o (last_latency),
    .max_latency_o  (max_latency)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit model_on = 1'b0;

  // reference model state
  bit     m_busy;
  int     m_cnt, m_iss, m_cmp;
  bit     m_proto;
  longint m_last, m_max;
  int     m_done_at, m_last_iss, m_last_cmp;
  int     ts_q[$];
  int     pend[$];
  int     last_sched;

  // monitors over DUT outputs for directed literal checks
  int start_hi = 0;
  int dp_cnt   = 0;
  int peak     = 0;
  int rises[$];
  bit prev_start = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s @cycle %0d: wait bound expired", name, cyc);
  endtask

  function automatic longint exp_lat(input longint x);
    return STATS ? x : 64'd0;
  endfunction

  function automatic bit exp_start();
    return m_busy && (m_iss < m_cnt) && ((m_iss - m_cmp) < MAX_OUT);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cnt = 0; m_iss = 0; m_cmp = 0; m_proto = 0;
    m_last = 0; m_max = 0; m_done_at = -1; m_last_iss = 0; m_last_cmp = 0;
    ts_q.delete();
    pend.delete();
    last_sched = 0;
  endtask

  // One clock edge of the reference model; c is the cycle that is ending.
  task automatic model_step();
    int  c, outst, lat, t;
    bit  hs, dn, acc;
    c = cyc;
    if (reset) begin
      model_reset();
      model_on = 1'b1;
    end else if (model_on) begin
      hs  = exp_start() && ap_ready;
      dn  = ap_done;
      acc = cmd_valid && !m_busy;
      if (acc) begin
        m_busy = 1; m_cnt = int'(cmd_count); m_iss = 0; m_cmp = 0;
        m_proto = dn; m_max = 0;
        ts_q.delete();
        m_done_at = (cmd_count == 0) ? c + 1 : -1;
      end else begin
        outst = m_iss - m_cmp;
        if (dn) begin
          if (outst > 0 || hs) begin
            lat = (outst == 0) ? 0 : c - ts_q.pop_front();
            m_cmp++;
            m_last = lat;
            if (lat >= m_max) m_max = lat;
            m_last_cmp = c;
          end else begin
            m_proto = 1;
          end
        end
        if (hs) begin
          if (!(dn && outst == 0)) ts_q.push_back(c);
          m_iss++;
          if (m_iss == m_cnt) m_last_iss = c;
          if (!tie_mode) begin
            t = c + $urandom_range(dmax, dmin);
            if (t <= last_sched) t = last_sched + 1;
            pend.push_back(t);
            last_sched = t;
          end
        end
        if (m_busy && m_done_at < 0 && m_cnt > 0 && m_iss == m_cnt && m_cmp == m_cnt)
          m_done_at = ((m_last_cmp > m_last_iss + 1) ? m_last_cmp : m_last_iss + 1) + 1;
        if (m_busy && c == m_done_at) m_busy = 0;
      end
    end
    cyc = cyc + 1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Core model: random ready, in-order done pulses at their scheduled cycles.
  initial begin
    forever begin
      @(negedge clk);
      rdy_drv = ($urandom_range(99) < rdy_pct);
      if (pend.size() > 0 && pend[0] == cyc) begin
        done_drv = 1'b1;
        void'(pend.pop_front());
      end else begin
        done_drv = 1'b0;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        chk("cmd_ready",   cmd_ready,    !m_busy);
        chk("busy",        busy,         m_busy);
        chk("ap_start",    ap_start,     exp_start());
        chk("done_pulse",  done_pulse,   m_busy && (cyc == m_done_at));
        chk("issued",      issued,       m_iss);
        chk("completed",   completed,    m_cmp);
        chk("proto_err",   proto_err,    m_proto);
        chk("ap_continue", ap_continue,  1);
        chk("last_lat",    last_latency, exp_lat(m_last));
        chk("max_lat",     max_latency,  exp_lat(m_max));
        if (ap_start) start_hi++;
        if (done_pulse) dp_cnt++;
        if (ap_start && !prev_start) rises.push_back(cyc);
        prev_start = ap_start;
        if (int'(issued) - int'(completed) > peak) peak = int'(issued) - int'(completed);
      end
    end
  end

  task automatic run_cmd(input int cnt, output int acc, output int dp);
    int n;
    acc = -1;
    dp  = -1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_count = cnt[NUM_W-1:0];
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      timeout_fail("cmd_accept");
      return;
    end
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!done_pulse && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done_pulse) dp = cyc;
    else timeout_fail("done_pulse_wait");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dp, n, s0, d0, cnt;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_count = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_busy",      busy,         0);
    chk("rst_cmd_ready", cmd_ready,    1);
    chk("rst_ap_start",  ap_start,     0);
    chk("rst_issued",    issued,       0);
    chk("rst_last_lat",  last_latency, 0);

    // three transactions, ready with start, done 5 cycles after ready
    rdy_pct = 100; dmin = 5; dmax = 5;
    d0 = dp_cnt;
    run_cmd(3, acc, dp);
    chk("t1_dp_offset",  dp - acc,     9);
    chk("t1_issued",     issued,       3);
    chk("t1_completed",  completed,    3);
    chk("t1_last_lat",   last_latency, exp_lat(5));
    chk("t1_max_lat",    max_latency,  exp_lat(5));
    chk("t1_model_last", m_last,       5);
    @(negedge clk);
    chk("t1_dp_once",    dp_cnt - d0,  1);

    // in-flight limit: done withheld 10 cycles
    dmin = 10; dmax = 10;
    peak = 0;
    rises.delete();
    run_cmd(8, acc, dp);
    chk("t2_dp_offset",  dp - acc,     26);
    chk("t2_issued",     issued,       8);
    chk("t2_completed",  completed,    8);
    chk("t2_peak_out",   peak,         MAX_OUT);
    chk("t2_rise_count", rises.size(), 2);
    chk("t2_resume",     (rises.size() >= 2) ? rises[1] - acc : -1, 12);
    chk("t2_max_lat",    max_latency,  exp_lat(10));
    chk("t2_model_max",  m_max,        10);

    // combinational core: ready and done follow ap_start
    @(negedge clk);
    tie_mode = 1'b1;
    s0 = start_hi;
    run_cmd(2, acc, dp);
    chk("t3_dp_offset",  dp - acc,     4);
    chk("t3_starts",     start_hi - s0, 2);
    chk("t3_completed",  completed,    2);
    chk("t3_proto",      proto_err,    0);
    chk("t3_last_lat",   last_latency, 0);
    chk("t3_max_lat",    max_latency,  0);
    @(negedge clk);
    tie_mode = 1'b0;

    // stray done while idle
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    chk("t4_proto_set",  proto_err,    1);
    chk("t4_completed",  completed,    2);

    // zero-length command clears the error and never starts
    s0 = start_hi;
    run_cmd(0, acc, dp);
    chk("t5_dp_offset",  dp - acc,     1);
    chk("t5_no_start",   start_hi - s0, 0);
    chk("t5_proto_clr",  proto_err,    0);
    chk("t5_issued",     issued,       0);

    // reset in the middle of a run with two outstanding
    dmin = 30; dmax = 30; rdy_pct = 100;
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_count = 16'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (issued != 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (issued != 2) timeout_fail("t6_wait_two");
    reset = 1'b1;
    @(negedge clk);
    chk("t6_ap_start",   ap_start,     0);
    chk("t6_busy",       busy,         0);
    chk("t6_issued",     issued,       0);
    chk("t6_completed",  completed,    0);
    chk("t6_cmd_ready",  cmd_ready,    1);
    chk("t6_last_lat",   last_latency, 0);
    chk("t6_max_lat",    max_latency,  0);
    reset = 1'b0;

    // randomized commands
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      tie_mode = ($urandom_range(7) == 0);
      rdy_pct  = $urandom_range(100, 20);
      dmin     = 1 + $urandom_range(2);
      dmax     = dmin + $urandom_range(10);
      cnt      = $urandom_range(12);
      if (!tie_mode && $urandom_range(3) == 0) begin
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
      end
      run_cmd(cnt, acc, dp);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
